// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: initial AddRoundKey, then one ISSUE/WAIT handshake per round
// with an external round datapath, holding the ciphertext until the consumer takes it.
module aes_round_ctrl #(
    parameter int NK    = 4,
    parameter int KEY_W = 4 * (NK + 7) * 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    input  logic [KEY_W-1:0] key,
    output logic             rnd_start,
    output logic             rnd_last,
    output logic [127:0]     rnd_state,
    output logic [127:0]     rnd_key,
    input  logic             rnd_done,
    input  logic [127:0]     rnd_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block
);

    localparam int         NR        = NK + 6;
    localparam logic [3:0] LastRound = 4'(NR);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_r0;

    assign key_r0 = key[KEY_W-1 -: 128];

    // Round key is a pure mux on the counter so it is valid in the same cycle as rnd_start.
    always_comb begin
        rnd_key = '0;
        for (int r = 0; r <= NR; r++) begin
            if (round_q == 4'(r)) begin
                rnd_key = key[KEY_W-1-128*r -: 128];
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = in_block ^ key_r0;
                    round_d = 4'd1;
                    fsm_d   = StIssue;
                end
            end
            StIssue: begin
                fsm_d = StWait;
            end
            StWait: begin
                if (rnd_done) begin
                    state_d = rnd_result;
                    if (round_q == LastRound) begin
                        fsm_d = StDone;
                    end else begin
                        round_d = round_q + 4'd1;
                        fsm_d   = StIssue;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    round_d = '0;
                    fsm_d   = StIdle;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= StIdle;
            round_q <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    assign in_ready  = (fsm_q == StIdle);
    assign rnd_start = (fsm_q == StIssue);
    assign rnd_last  = (round_q == LastRound);
    assign rnd_state = state_q;
    assign out_valid = (fsm_q == StDone);
    assign out_block = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES model drives a stalling round datapath and a
// per-cycle compare process checks the controller against transaction-level expectations.
module tb_aes_round_ctrl;

    localparam int KEY_W = 1408;
    localparam logic [127:0] FipsKey = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] FipsPt  = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] FipsCt  = 128'h29c3505f571420f6402299b31a02d73a;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_block;
    logic [KEY_W-1:0] key;
    logic             rnd_start;
    logic             rnd_last;
    logic [127:0]     rnd_state;
    logic [127:0]     rnd_key;
    logic             rnd_done;
    logic [127:0]     rnd_result;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_block;

    aes_round_ctrl #(.NK(4), .KEY_W(KEY_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .key       (key),
        .rnd_start (rnd_start),
        .rnd_last  (rnd_last),
        .rnd_state (rnd_state),
        .rnd_key   (rnd_key),
        .rnd_done  (rnd_done),
        .rnd_result(rnd_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int max_delay = 0;
    int stale_req = 0;
    int stale_ack = 0;
    logic [7:0] sbox_t [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] y = 8'h01;
        for (int i = 0; i < 254; i++) y = gmul(y, x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox_t[st[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [KEY_W-1:0] key_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0] rc = 8'h01;
        logic [KEY_W-1:0] s;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) s[KEY_W-1-32*i -: 32] = w[i];
        return s;
    endfunction

    function automatic logic [127:0] rk(input logic [KEY_W-1:0] s, input int r);
        return s[KEY_W-1-128*r -: 128];
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] blk,
                                                 input logic [KEY_W-1:0] s);
        logic [127:0] st = blk ^ rk(s, 0);
        for (int r = 1; r <= 10; r++) st = aes_round(st, rk(s, r), r == 10);
        return st;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Round datapath: responds to each rnd_start after a random stall; also injects stray
    // rnd_done pulses on request.
    initial begin : responder
        logic [127:0] r;
        int d;
        rnd_done = 1'b0;
        rnd_result = '0;
        forever begin
            @(negedge clk);
            if (rnd_start && !reset) begin
                r = aes_round(rnd_state, rnd_key, rnd_last);
                d = (max_delay == 0) ? 0 : $urandom_range(max_delay, 0);
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                rnd_done = 1'b1;
                rnd_result = r;
                @(posedge clk);
                #1;
                rnd_done = 1'b0;
                rnd_result = rand128();
            end else if (stale_ack != stale_req) begin
                stale_ack++;
                @(posedge clk);
                #1;
                rnd_done = 1'b1;
                rnd_result = rand128();
                @(posedge clk);
                #1;
                rnd_done = 1'b0;
            end
        end
    end

    // Reference model: 0 idle, 1 busy with a block, 2 ciphertext held.
    int m_mode = 0;
    bit m_known = 1'b0;
    bit m_exp_start = 1'b0;
    bit m_pending = 1'b0;
    bit m_after_rst = 1'b0;
    bit m_first_done = 1'b0;
    bit m_nostall = 1'b0;
    int m_starts = 0;
    int n_pulses = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int acc_cnt = 0;
    logic [127:0] m_state = '0;
    logic [127:0] m_golden = '0;

    always @(negedge clk) begin
        cyc++;
        if (m_known) begin
            chk("in_ready", 128'(in_ready), 128'(m_mode == 0));
            chk("out_valid", 128'(out_valid), 128'(m_mode == 2));
            chk("rnd_start", 128'(rnd_start), 128'(m_exp_start));
            if (m_after_rst) begin
                chk("rst_state", rnd_state, '0);
                chk("rst_key", rnd_key, rk(key, 0));
                chk("rst_last", 128'(rnd_last), '0);
            end
            if (rnd_start && m_exp_start) begin
                chk("rnd_state", rnd_state, m_state);
                chk("rnd_key", rnd_key, rk(key, m_starts + 1));
                chk("rnd_last", 128'(rnd_last), 128'(m_starts == 9));
            end
            if (rnd_start && m_mode == 1) n_pulses++;
            if (out_valid && m_mode == 2) begin
                chk("out_block", out_block, m_state);
                chk("out_golden", out_block, m_golden);
                if (m_first_done) begin
                    chk("n_starts", 128'(n_pulses), 128'(10));
                    if (m_nostall) chk("latency", 128'(cyc - acc_cyc), 128'(21));
                    done_cyc = cyc;
                end
            end
        end
        if (reset) begin
            m_known = 1'b1;
            m_mode = 0;
            m_state = '0;
            m_exp_start = 1'b0;
            m_pending = 1'b0;
            m_after_rst = 1'b1;
        end else if (m_known) begin
            m_after_rst = 1'b0;
            case (m_mode)
                0: if (in_valid) begin
                    m_mode = 1;
                    m_state = in_block ^ rk(key, 0);
                    m_golden = aes_encrypt(in_block, key);
                    m_starts = 0;
                    m_exp_start = 1'b1;
                    n_pulses = 0;
                    acc_cyc = cyc;
                    m_nostall = (max_delay == 0);
                    acc_cnt++;
                end
                1: if (m_exp_start) begin
                    m_exp_start = 1'b0;
                    m_starts++;
                    m_pending = 1'b1;
                end else if (m_pending && rnd_done) begin
                    m_state = aes_round(m_state, rk(key, m_starts), m_starts == 10);
                    m_pending = 1'b0;
                    if (m_starts == 10) begin
                        m_mode = 2;
                        m_first_done = 1'b1;
                    end else begin
                        m_exp_start = 1'b1;
                    end
                end
                default: begin
                    m_first_done = 1'b0;
                    if (out_ready) m_mode = 0;
                end
            endcase
        end
    end

    task automatic send(input logic [127:0] blk);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_block = blk;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_out", 128'(ok), 128'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit found;
        int cnt;
        int prev;
        for (int i = 0; i < 256; i++) sbox_t[i] = calc_sbox(8'(i));
        reset = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        out_ready = 1'b0;
        key = key_expand(FipsKey);
        chk("model_rk1", rk(key, 1), 128'hE232FCF191129188B159E4E6D679A293);
        chk("model_enc", aes_encrypt(FipsPt, key), FipsCt);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Known-answer block with a 1-cycle datapath.
        max_delay = 0;
        out_ready = 1'b1;
        send(FipsPt);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (rnd_start) found = 1'b1;
        end
        chk("first_issue", 128'(found), 128'(1));
        chk("kat_state", rnd_state, 128'h001f0e543c4e08596e221b0b4774311a);
        chk("kat_key", rnd_key, 128'hE232FCF191129188B159E4E6D679A293);
        wait_out(40);
        chk("kat_ct", out_block, FipsCt);

        // Random keys and blocks with datapath stalls.
        max_delay = 5;
        for (int b = 0; b < 6; b++) begin
            @(posedge clk);
            #1;
            key = key_expand(rand128());
            send(rand128());
            wait_out(200);
        end

        // Output backpressure with in_valid pulses that must be dropped.
        max_delay = 0;
        out_ready = 1'b0;
        send(rand128());
        wait_out(60);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(1, 0));
            in_block = rand128();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);

        // Reset in round 5, stray rnd_done while idle, then a clean block.
        max_delay = 3;
        send(rand128());
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 5; i++) begin
            @(negedge clk);
            if (rnd_start) cnt++;
        end
        chk("reach_round5", 128'(cnt), 128'(5));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        stale_req++;
        repeat (4) @(posedge clk);
        max_delay = 0;
        send(rand128());
        wait_out(60);

        // Back-to-back blocks with in_valid held high.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_block = rand128();
        for (int b = 0; b < 3; b++) begin
            prev = acc_cnt;
            found = 1'b0;
            for (int i = 0; i < 60 && !found; i++) begin
                @(negedge clk);
                if (acc_cnt != prev) found = 1'b1;
            end
            chk("b2b_accept", 128'(found), 128'(1));
            if (b > 0) chk("b2b_gap", 128'(acc_cyc - done_cyc), 128'(1));
            @(posedge clk);
            #1;
            in_block = rand128();
            if (b == 2) in_valid = 1'b0;
        end
        wait_out(60);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
